pr_region_freeze_ctrl: RTL and testbench



---
 rtl/pr_ctrl_pkg.sv | 14 +
 rtl/pr_req_edge_detect.sv | 28 ++
 rtl/pr_region_freeze_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pr_region_freeze_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pr_ctrl_pkg.sv
// rtl/pr_ctrl_pkg.sv - shared types and constants for the PR region freeze controller
package pr_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    STOP_WAIT  = 2'd1,
    FROZEN     = 2'd2,
    START_WAIT = 2'd3
  } pr_state_e;

  localparam int ILL_FREEZE   = 0;
  localparam int ILL_UNFREEZE = 1;

endpackage

// File: rtl/pr_req_edge_detect.sv
// rtl/pr_req_edge_detect.sv - registered rising-edge detector for a level request bit
module pr_req_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic req,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  // Previous-level tracking; resets high so a request held across reset must be re-raised
  always_comb begin
    prev_d = req;
  end

  // Previous-level register
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = req & ~prev_q;

endmodule

// File: rtl/pr_region_freeze_ctrl.sv
// rtl/pr_region_freeze_ctrl.sv - per-region PR freeze controller; optional watchdog via PR_FREEZE_TIMEOUT_EN
module pr_region_freeze_ctrl
  import pr_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int TIMEOUT_W      = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       freeze_req,
  input  logic       unfreeze_req,
  input  logic       reset_req,
  output logic       freeze_status,
  output logic       unfreeze_status,
  output logic [1:0] illegal_req,
  output logic       stop_req,
  input  logic       stop_ack,
  output logic       start_req,
  input  logic       start_ack,
  output logic       freeze,
  output logic       region_reset,
  output logic       timeout_flag
);

  pr_state_e  state_q, state_d;
  logic [1:0] ill_q, ill_d;
  logic       ustat_q, ustat_d;
  logic       rreset_q, rreset_d;
  logic       frz_rise;
  logic       unf_rise;
  logic       accept_freeze;
  logic       wd_expired;

  pr_req_edge_detect u_frz_edge (
    .clk   (clk),
    .reset (reset),
    .req   (freeze_req),
    .rise  (frz_rise)
  );

  pr_req_edge_detect u_unf_edge (
    .clk   (clk),
    .reset (reset),
    .req   (unfreeze_req),
    .rise  (unf_rise)
  );

  assign accept_freeze = (state_q == RUN) && frz_rise;

`ifdef PR_FREEZE_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  logic [TIMEOUT_W-1:0] wd_cnt_q, wd_cnt_d;
  logic                 tflag_q, tflag_d;

  assign wd_expired = (state_q == STOP_WAIT) && (wd_cnt_q == WD_LAST);

  // Watchdog counts cycles spent in STOP_WAIT; flag marks a forced stop until the next accepted freeze
  always_comb begin
    wd_cnt_d = '0;
    tflag_d  = tflag_q;
    if (state_q == STOP_WAIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
    end
    if (accept_freeze) begin
      tflag_d = 1'b0;
    end
    if (wd_expired && !stop_ack) begin
      tflag_d = 1'b1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
      tflag_q  <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      tflag_q  <= tflag_d;
    end
  end

  assign timeout_flag = tflag_q;
`else
  assign wd_expired = 1'b0;
  // Constant 0; the expression only keeps the watchdog parameters referenced in this build
  assign timeout_flag = (TIMEOUT_CYCLES < 0) && (TIMEOUT_W < 0);
`endif

  // Next-state, sticky illegal flags, unfreeze status and frozen-only region reset
  always_comb begin
    state_d  = state_q;
    ill_d    = ill_q;
    ustat_d  = ustat_q;
    rreset_d = 1'b0;

    if (frz_rise && (state_q != RUN)) begin
      ill_d[ILL_FREEZE] = 1'b1;
    end
    if (!freeze_req) begin
      ill_d[ILL_FREEZE] = 1'b0;
    end
    if (unf_rise && (state_q != FROZEN)) begin
      ill_d[ILL_UNFREEZE] = 1'b1;
    end
    if (!unfreeze_req) begin
      ill_d[ILL_UNFREEZE] = 1'b0;
    end

    case (state_q)
      RUN: begin
        if (frz_rise) begin
          state_d = STOP_WAIT;
          ustat_d = 1'b0;
        end
      end
      STOP_WAIT: begin
        if (stop_ack || wd_expired) begin
          state_d = FROZEN;
        end
      end
      FROZEN: begin
        if (unf_rise) begin
          state_d = START_WAIT;
        end else begin
          rreset_d = reset_req;
        end
      end
      START_WAIT: begin
        if (start_ack) begin
          state_d = RUN;
          ustat_d = 1'b1;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Controller registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      ill_q    <= 2'b00;
      ustat_q  <= 1'b0;
      rreset_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ill_q    <= ill_d;
      ustat_q  <= ustat_d;
      rreset_q <= rreset_d;
    end
  end

  assign stop_req        = (state_q == STOP_WAIT);
  assign start_req       = (state_q == START_WAIT);
  assign freeze          = (state_q == FROZEN);
  assign freeze_status   = (state_q == FROZEN);
  assign unfreeze_status = ustat_q;
  assign illegal_req     = ill_q;
  assign region_reset    = rreset_q;

endmodule

// File: tb/tb_pr_region_freeze_ctrl.sv
// tb/tb_pr_region_freeze_ctrl.sv - self-checking bench for pr_region_freeze_ctrl
module tb_pr_region_freeze_ctrl;

`ifdef PR_FREEZE_TIMEOUT_EN
  localparam int TC     = 8;
  localparam bit TO_EN  = 1'b1;
`else
  localparam int TC     = 50000;
  localparam bit TO_EN  = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       freeze_req, unfreeze_req, reset_req, stop_ack, start_ack;
  logic       freeze_status, unfreeze_status, stop_req, start_req, freeze, region_reset, timeout_flag;
  logic [1:0] illegal_req;
  logic [8:0] dut_vec;

  int n_cmp = 0;
  int n_bad = 0;

  pr_region_freeze_ctrl #(.TIMEOUT_CYCLES(TC), .TIMEOUT_W(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .freeze_req      (freeze_req),
    .unfreeze_req    (unfreeze_req),
    .reset_req       (reset_req),
    .freeze_status   (freeze_status),
    .unfreeze_status (unfreeze_status),
    .illegal_req     (illegal_req),
    .stop_req        (stop_req),
    .stop_ack        (stop_ack),
    .start_req       (start_req),
    .start_ack       (start_ack),
    .freeze          (freeze),
    .region_reset    (region_reset),
    .timeout_flag    (timeout_flag)
  );

  always #5 clk = ~clk;

  assign dut_vec = {freeze_status, unfreeze_status, illegal_req, stop_req, start_req,
                    freeze, region_reset, timeout_flag};

  // Behavioural reference: which handshake phase the region is in, plus the status bits
  localparam int PH_RUNNING  = 0;
  localparam int PH_STOPPING = 1;
  localparam int PH_FROZEN   = 2;
  localparam int PH_STARTING = 3;

  int   m_phase = PH_RUNNING;
  int   m_wait  = 0;
  bit   m_prev_f = 1'b1, m_prev_u = 1'b1;
  bit   m_ill_f = 1'b0, m_ill_u = 1'b0;
  bit   m_ustat = 1'b0, m_rrst = 1'b0, m_tflag = 1'b0;

  function automatic logic [8:0] model_vec();
    return {m_phase == PH_FROZEN, m_ustat, m_ill_u, m_ill_f, m_phase == PH_STOPPING,
            m_phase == PH_STARTING, m_phase == PH_FROZEN, m_rrst, m_tflag};
  endfunction

  task automatic model_step();
    bit rf, ru;
    rf = freeze_req && !m_prev_f;
    ru = unfreeze_req && !m_prev_u;
    if (reset) begin
      m_phase = PH_RUNNING; m_wait = 0; m_prev_f = 1; m_prev_u = 1;
      m_ill_f = 0; m_ill_u = 0; m_ustat = 0; m_rrst = 0; m_tflag = 0;
      return;
    end
    if (rf && m_phase != PH_RUNNING) m_ill_f = 1;
    if (!freeze_req) m_ill_f = 0;
    if (ru && m_phase != PH_FROZEN) m_ill_u = 1;
    if (!unfreeze_req) m_ill_u = 0;
    m_rrst = 0;
    case (m_phase)
      PH_RUNNING: if (rf) begin m_phase = PH_STOPPING; m_ustat = 0; m_tflag = 0; m_wait = 0; end
      PH_STOPPING: begin
        if (stop_ack) m_phase = PH_FROZEN;
        else if (TO_EN && m_wait == TC - 1) begin m_phase = PH_FROZEN; m_tflag = 1; end
        else m_wait++;
      end
      PH_FROZEN: if (ru) m_phase = PH_STARTING; else m_rrst = reset_req;
      default: if (start_ack) begin m_phase = PH_RUNNING; m_ustat = 1; end
    endcase
    m_prev_f = freeze_req;
    m_prev_u = unfreeze_req;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    freeze_req = 0; unfreeze_req = 0; reset_req = 0; stop_ack = 0; start_ack = 0;
    reset = 1;
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_reset();
    freeze_req = 1; unfreeze_req = 1; reset_req = 1; stop_ack = 0; start_ack = 0;
    reset = 1;
    tick(); tick();
    n_cmp++;
    if (dut_vec !== 9'b0) begin n_bad++; $display("FAIL reset_outputs: got %b want %b", dut_vec, 9'b0); end
    reset = 0;
    repeat (3) tick();
    n_cmp++;
    if ({stop_req, start_req, freeze, illegal_req} !== 5'b0) begin
      n_bad++; $display("FAIL held_req_after_reset: got %b want %b", {stop_req, start_req, freeze, illegal_req}, 5'b0);
    end
  endtask

  task automatic test_normal_cycle();
    do_reset();
    freeze_req = 1; tick();
    n_cmp++;
    if ({stop_req, freeze, unfreeze_status} !== 3'b100) begin
      n_bad++; $display("FAIL stop_req_rise: got %b want %b", {stop_req, freeze, unfreeze_status}, 3'b100);
    end
    repeat (3) tick();
    n_cmp++;
    if ({stop_req, freeze} !== 2'b10) begin n_bad++; $display("FAIL stop_wait_hold: got %b want %b", {stop_req, freeze}, 2'b10); end
    stop_ack = 1; tick(); stop_ack = 0;
    n_cmp++;
    if ({stop_req, freeze, freeze_status} !== 3'b011) begin
      n_bad++; $display("FAIL frozen_entry: got %b want %b", {stop_req, freeze, freeze_status}, 3'b011);
    end
    freeze_req = 0; repeat (3) tick();
    unfreeze_req = 1; tick();
    n_cmp++;
    if ({freeze, freeze_status, start_req} !== 3'b001) begin
      n_bad++; $display("FAIL unfreeze_accept: got %b want %b", {freeze, freeze_status, start_req}, 3'b001);
    end
    repeat (2) tick();
    start_ack = 1; tick(); start_ack = 0;
    n_cmp++;
    if ({start_req, unfreeze_status, stop_req, freeze} !== 4'b0100) begin
      n_bad++; $display("FAIL run_return: got %b want %b", {start_req, unfreeze_status, stop_req, freeze}, 4'b0100);
    end
    unfreeze_req = 0; tick();
    stop_ack = 1; start_ack = 1; tick(); tick(); stop_ack = 0; start_ack = 0;
    n_cmp++;
    if ({stop_req, start_req, freeze, unfreeze_status} !== 4'b0001) begin
      n_bad++; $display("FAIL stray_ack_ignored: got %b want %b", {stop_req, start_req, freeze, unfreeze_status}, 4'b0001);
    end
  endtask

  task automatic test_region_reset();
    do_reset();
    reset_req = 1; repeat (2) tick();
    n_cmp++;
    if ({region_reset, illegal_req} !== 3'b000) begin
      n_bad++; $display("FAIL reset_req_in_run: got %b want %b", {region_reset, illegal_req}, 3'b000);
    end
    reset_req = 0;
    freeze_req = 1; tick(); stop_ack = 1; tick(); stop_ack = 0;
    reset_req = 1; tick();
    n_cmp++;
    if ({region_reset, freeze} !== 2'b11) begin n_bad++; $display("FAIL region_reset_on: got %b want %b", {region_reset, freeze}, 2'b11); end
    unfreeze_req = 1; tick();
    n_cmp++;
    if ({region_reset, freeze, start_req} !== 3'b001) begin
      n_bad++; $display("FAIL region_reset_drop: got %b want %b", {region_reset, freeze, start_req}, 3'b001);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    unfreeze_req = 1; tick();
    n_cmp++;
    if ({illegal_req, stop_req, start_req, freeze} !== 5'b10000) begin
      n_bad++; $display("FAIL illegal_unfreeze_run: got %b want %b", {illegal_req, stop_req, start_req, freeze}, 5'b10000);
    end
    unfreeze_req = 0; tick();
    n_cmp++;
    if (illegal_req !== 2'b00) begin n_bad++; $display("FAIL illegal_clear: got %b want %b", illegal_req, 2'b00); end
    freeze_req = 1; tick(); stop_ack = 1; tick(); stop_ack = 0; freeze_req = 0;
    unfreeze_req = 1; tick();
    freeze_req = 1; tick();
    n_cmp++;
    if ({illegal_req, start_req} !== 3'b011) begin
      n_bad++; $display("FAIL illegal_freeze_start_wait: got %b want %b", {illegal_req, start_req}, 3'b011);
    end
    freeze_req = 0; tick();
    n_cmp++;
    if ({illegal_req, start_req} !== 3'b001) begin
      n_bad++; $display("FAIL illegal_freeze_clear: got %b want %b", {illegal_req, start_req}, 3'b001);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    freeze_req = 1; unfreeze_req = 1; tick();
    n_cmp++;
    if ({stop_req, illegal_req} !== 3'b110) begin
      n_bad++; $display("FAIL simul_run: got %b want %b", {stop_req, illegal_req}, 3'b110);
    end
    stop_ack = 1; tick(); stop_ack = 0;
    freeze_req = 0; unfreeze_req = 0; tick();
    freeze_req = 1; unfreeze_req = 1; tick();
    n_cmp++;
    if ({start_req, freeze, illegal_req} !== 4'b1001) begin
      n_bad++; $display("FAIL simul_frozen: got %b want %b", {start_req, freeze, illegal_req}, 4'b1001);
    end
  endtask

  task automatic test_reset_midhandshake();
    do_reset();
    freeze_req = 1; tick();
    reset = 1; tick(); reset = 0;
    n_cmp++;
    if (dut_vec !== 9'b0) begin n_bad++; $display("FAIL reset_in_stop_wait: got %b want %b", dut_vec, 9'b0); end
    repeat (3) tick();
    n_cmp++;
    if (stop_req !== 1'b0) begin n_bad++; $display("FAIL no_refire_after_reset: got %b want %b", stop_req, 1'b0); end
    freeze_req = 0; tick(); freeze_req = 1; tick(); stop_ack = 1; tick(); stop_ack = 0;
    reset_req = 1; tick();
    reset = 1; tick(); reset = 0;
    n_cmp++;
    if (dut_vec !== 9'b0) begin n_bad++; $display("FAIL reset_in_frozen: got %b want %b", dut_vec, 9'b0); end
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    freeze_req = 1; tick();
`ifdef PR_FREEZE_TIMEOUT_EN
    repeat (TC - 1) tick();
    n_cmp++;
    if ({freeze, stop_req} !== 2'b01) begin n_bad++; $display("FAIL timeout_early: got %b want %b", {freeze, stop_req}, 2'b01); end
    tick();
    n_cmp++;
    if ({freeze, stop_req, timeout_flag} !== 3'b101) begin
      n_bad++; $display("FAIL timeout_fire: got %b want %b", {freeze, stop_req, timeout_flag}, 3'b101);
    end
    freeze_req = 0; unfreeze_req = 1; tick(); start_ack = 1; tick(); start_ack = 0; unfreeze_req = 0; tick();
    n_cmp++;
    if (timeout_flag !== 1'b1) begin n_bad++; $display("FAIL timeout_sticky: got %b want %b", timeout_flag, 1'b1); end
    freeze_req = 1; tick();
    n_cmp++;
    if ({timeout_flag, stop_req} !== 2'b01) begin
      n_bad++; $display("FAIL timeout_clear: got %b want %b", {timeout_flag, stop_req}, 2'b01);
    end
`else
    ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if ({stop_req, freeze, timeout_flag} !== 3'b100) ok = 1'b0;
    end
    n_cmp++;
    if (!ok) begin
      n_bad++; $display("FAIL no_timeout: got %b want %b", {stop_req, freeze, timeout_flag}, 3'b100);
    end
`endif
  endtask

  task automatic test_random();
    int shown = 0;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 5) == 0) freeze_req = ~freeze_req;
      if ($urandom_range(0, 5) == 0) unfreeze_req = ~unfreeze_req;
      reset_req    = $urandom_range(0, 1);
      stop_ack     = ($urandom_range(0, 5) == 0);
      start_ack    = ($urandom_range(0, 3) == 0);
      tick();
      n_cmp++;
      if (dut_vec !== model_vec()) begin
        n_bad++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random_cycle_%0d: got %b want %b", i, dut_vec, model_vec());
        end
      end
    end
    reset = 0;
  endtask

  initial begin
    reset = 1; freeze_req = 0; unfreeze_req = 0; reset_req = 0; stop_ack = 0; start_ack = 0;
    @(negedge clk);
    test_reset();
    test_normal_cycle();
    test_region_reset();
    test_illegal();
    test_simultaneous();
    test_reset_midhandshake();
    test_timeout();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
